// File: rtl/lmsm_pkg.sv
// Shared types and constants for the LM/SM micro-op sequencer.
package lmsm_pkg;

  localparam int LMSM_MASK_W = 8;

  localparam logic [3:0] OP_LM = 4'd6;
  localparam logic [3:0] OP_SM = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } lmsm_state_t;

  function automatic logic is_one_hot(input logic [LMSM_MASK_W-1:0] m);
    return (m != '0) && ((m & (m - LMSM_MASK_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Highest-set-bit encoder for an 8-bit mask; one_hot_left flags a single remaining bit.
module prio_enc8
  import lmsm_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [2:0] idx_o,
  output logic       one_hot_left
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (in_i[i]) idx_o = 3'(i);
    end
  end

  assign one_hot_left = is_one_hot(in_i);

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands an LM/SM register mask into single-register micro-ops, R7 first.
// LMSM_SKIP_ZERO_EN: skip zero mask bits (no bubbles); otherwise scan all 8 positions.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int MASK_W = 8,
  parameter int PC_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [2:0]                base_reg,
  input  logic [MASK_W-1:0]         mask,
  input  logic [PC_W-1:0]           pc_in,
  input  logic                      flush,
  input  logic                      uop_ready,
  output logic                      busy,
  output logic                      uop_valid,
  output logic [3:0]                uop_opcode,
  output logic [2:0]                uop_base,
  output logic [$clog2(MASK_W)-1:0] uop_reg,
  output logic [$clog2(MASK_W)-1:0] uop_offset,
  output logic [PC_W-1:0]           uop_pc,
  output logic                      uop_last,
  output logic                      freeze_release
);

  localparam int IDX_W = $clog2(MASK_W);

  lmsm_state_t       state_q, state_d;
  logic [MASK_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0]  off_q, off_d;
  logic              store_q;
  logic [2:0]        base_q;
  logic [PC_W-1:0]   pc_q;

  logic [IDX_W-1:0]  cur_idx;
  logic              have_uop;
  logic              last_w;
  logic              fire;

`ifdef LMSM_SKIP_ZERO_EN
  prio_enc8 u_enc (
    .in_i         (rem_q),
    .idx_o        (cur_idx),
    .one_hot_left (last_w)
  );
  // rem_q is never empty while in ISSUE, so a micro-op is always present
  assign have_uop = 1'b1;
`else
  logic [IDX_W-1:0] pos_q, pos_d;

  assign cur_idx  = pos_q;
  assign have_uop = rem_q[pos_q];
  assign last_w   = is_one_hot(rem_q);
`endif

  assign uop_valid      = (state_q == ISSUE) && have_uop;
  assign uop_last       = uop_valid && last_w;
  assign busy           = (state_q != IDLE);
  assign freeze_release = (state_q == RELEASE);
  assign fire           = uop_valid && uop_ready;

  assign uop_opcode = uop_valid ? (store_q ? OP_SM : OP_LM) : 4'd0;
  assign uop_base   = uop_valid ? base_q  : '0;
  assign uop_reg    = uop_valid ? cur_idx : '0;
  assign uop_offset = uop_valid ? off_q   : '0;
  assign uop_pc     = uop_valid ? pc_q    : '0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    off_d   = off_q;
`ifndef LMSM_SKIP_ZERO_EN
    pos_d   = pos_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = mask;
          off_d   = '0;
`ifndef LMSM_SKIP_ZERO_EN
          pos_d   = '1;
`endif
          state_d = (mask != '0) ? ISSUE : RELEASE;
        end
      end
      ISSUE: begin
        if (fire) begin
          rem_d = rem_q & ~(MASK_W'(1) << cur_idx);
          off_d = off_q + IDX_W'(1);
        end
`ifdef LMSM_SKIP_ZERO_EN
        if (fire && last_w) state_d = RELEASE;
`else
        // the scan always walks every position, so completion time is fixed
        if (fire || !have_uop) begin
          if (pos_q == '0) state_d = RELEASE;
          else             pos_d   = pos_q - IDX_W'(1);
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      off_q   <= '0;
`ifndef LMSM_SKIP_ZERO_EN
      pos_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      off_q   <= off_d;
`ifndef LMSM_SKIP_ZERO_EN
      pos_q   <= pos_d;
`endif
    end
  end

  // instruction fields only reach the outputs through uop_valid gating
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      store_q <= is_store;
      base_q  <= base_reg;
      pc_q    <= pc_in;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: slot-queue reference model checked every cycle plus literal expectations.
module tb_lmsm_sequencer;

`ifdef LMSM_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store, flush, uop_ready;
  logic [2:0]  base_reg;
  logic [7:0]  mask;
  logic [15:0] pc_in;
  logic        busy, uop_valid, uop_last, freeze_release;
  logic [3:0]  uop_opcode;
  logic [2:0]  uop_base, uop_reg, uop_offset;
  logic [15:0] uop_pc;

  lmsm_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .is_store       (is_store),
    .base_reg       (base_reg),
    .mask           (mask),
    .pc_in          (pc_in),
    .flush          (flush),
    .uop_ready      (uop_ready),
    .busy           (busy),
    .uop_valid      (uop_valid),
    .uop_opcode     (uop_opcode),
    .uop_base       (uop_base),
    .uop_reg        (uop_reg),
    .uop_offset     (uop_offset),
    .uop_pc         (uop_pc),
    .uop_last       (uop_last),
    .freeze_release (freeze_release)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an instruction is a queue of slots, each either a register
  // to issue (>=0) or a bubble (-1); an empty queue while active is the release cycle.
  int          slots[$];
  bit          m_active = 1'b0;
  int          m_issued;
  bit          m_store;
  logic [2:0]  m_base;
  logic [15:0] m_pc;

  int lg_reg[$], lg_off[$], lg_last[$];
  int start_edge = 0, first_lat = -1, rel_lat = -1, rel_cnt = 0, busy_cnt = 0;

  logic        e_busy, e_valid, e_last, e_rel;
  logic [3:0]  e_op;
  logic [2:0]  e_base, e_reg, e_off;
  logic [15:0] e_pc;

  always @(negedge clk) begin
    e_busy = 0; e_valid = 0; e_last = 0; e_rel = 0;
    e_op = 0; e_base = 0; e_reg = 0; e_off = 0; e_pc = 0;
    if (rst_n && m_active) begin
      e_busy = 1;
      if (slots.size() == 0) e_rel = 1;
      else if (slots[0] >= 0) begin
        e_valid = 1;
        e_op    = m_store ? 4'd7 : 4'd6;
        e_base  = m_base;
        e_reg   = 3'(slots[0]);
        e_off   = 3'(m_issued);
        e_pc    = m_pc;
        e_last  = 1;
        for (int i = 1; i < slots.size(); i++) if (slots[i] >= 0) e_last = 0;
      end
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("freeze_release", 32'(freeze_release), 32'(e_rel));
    chk("uop_valid", 32'(uop_valid), 32'(e_valid));
    if (e_valid) begin
      chk("uop_opcode", 32'(uop_opcode), 32'(e_op));
      chk("uop_base", 32'(uop_base), 32'(e_base));
      chk("uop_reg", 32'(uop_reg), 32'(e_reg));
      chk("uop_offset", 32'(uop_offset), 32'(e_off));
      chk("uop_pc", 32'(uop_pc), 32'(e_pc));
      chk("uop_last", 32'(uop_last), 32'(e_last));
    end

    if (rst_n) begin
      if (uop_valid && uop_ready && !flush) begin
        lg_reg.push_back(int'(uop_reg));
        lg_off.push_back(int'(uop_offset));
        lg_last.push_back(int'(uop_last));
      end
      if (uop_valid && first_lat < 0) first_lat = cyc - start_edge + 1;
      if (freeze_release) begin
        rel_cnt++;
        rel_lat = cyc - start_edge + 1;
      end
      if (busy) busy_cnt++;
    end

    if (!rst_n) begin
      m_active = 0;
      slots.delete();
    end else if (flush) begin
      m_active = 0;
      slots.delete();
    end else if (!m_active) begin
      if (start) begin
        m_active   = 1;
        m_issued   = 0;
        m_store    = is_store;
        m_base     = base_reg;
        m_pc       = pc_in;
        start_edge = cyc + 1;
        slots.delete();
        for (int i = 7; i >= 0; i--) begin
          if (mask[i]) slots.push_back(i);
          else if (!SKIP && mask != 8'h00) slots.push_back(-1);
        end
      end
    end else if (slots.size() == 0) begin
      m_active = 0;
    end else if (slots[0] < 0) begin
      void'(slots.pop_front());
    end else if (uop_ready) begin
      void'(slots.pop_front());
      m_issued++;
    end
  end

  task automatic clear_meas();
    lg_reg.delete(); lg_off.delete(); lg_last.delete();
    first_lat = -1; rel_lat = -1; rel_cnt = 0; busy_cnt = 0;
  endtask

  // called at posedge+1; start is sampled at the next edge
  task automatic do_start(input bit st, input logic [2:0] b, input logic [7:0] m, input logic [15:0] pc);
    start = 1; is_store = st; base_reg = b; mask = m; pc_in = pc;
    @(posedge clk); #1;
    start = 0; mask = 8'h00;
  endtask

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 0; start = 0; is_store = 0; base_reg = 0; mask = 0; pc_in = 0;
    flush = 0; uop_ready = 1;
    run(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(uop_valid), 0);
    chk("rst_release", 32'(freeze_release), 0);
    chk("rst_opcode", 32'(uop_opcode), 0);
    chk("rst_pc", 32'(uop_pc), 0);
    rst_n = 1;
    run(2);

    // LM, mask 1010_0001, base R2
    clear_meas();
    do_start(1'b0, 3'd2, 8'b1010_0001, 16'h1234);
    run(14);
    chk("t1_count", 32'(lg_reg.size()), 3);
    if (lg_reg.size() == 3) begin
      chk("t1_reg0", 32'(lg_reg[0]), 7); chk("t1_off0", 32'(lg_off[0]), 0); chk("t1_last0", 32'(lg_last[0]), 0);
      chk("t1_reg1", 32'(lg_reg[1]), 5); chk("t1_off1", 32'(lg_off[1]), 1); chk("t1_last1", 32'(lg_last[1]), 0);
      chk("t1_reg2", 32'(lg_reg[2]), 0); chk("t1_off2", 32'(lg_off[2]), 2); chk("t1_last2", 32'(lg_last[2]), 1);
    end
    chk("t1_first_lat", 32'(first_lat), 1);
    chk("t1_rel_lat", 32'(rel_lat), SKIP ? 4 : 9);
    chk("t1_rel_cnt", 32'(rel_cnt), 1);

    // SM, mask FF, ready low 3 cycles on the 2nd micro-op
    clear_meas();
    do_start(1'b1, 3'd5, 8'hFF, 16'hBEEF);
    run(1);
    uop_ready = 0;
    run(3);
    uop_ready = 1;
    run(14);
    chk("t2_count", 32'(lg_reg.size()), 8);
    if (lg_reg.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_reg", 32'(lg_reg[i]), 32'(7 - i));
        chk("t2_off", 32'(lg_off[i]), 32'(i));
        chk("t2_last", 32'(lg_last[i]), (i == 7) ? 1 : 0);
      end
    end
    chk("t2_rel_lat", 32'(rel_lat), 12);
    chk("t2_rel_cnt", 32'(rel_cnt), 1);

    // empty mask
    clear_meas();
    do_start(1'b0, 3'd1, 8'h00, 16'h0100);
    run(6);
    chk("t3_count", 32'(lg_reg.size()), 0);
    chk("t3_first_lat", 32'(first_lat), 32'(-1));
    chk("t3_rel_lat", 32'(rel_lat), 1);
    chk("t3_busy_cycles", 32'(busy_cnt), 1);

    // single low bit: bubbles in scan mode
    clear_meas();
    do_start(1'b0, 3'd3, 8'b0000_0100, 16'h0200);
    run(14);
    chk("t4_count", 32'(lg_reg.size()), 1);
    if (lg_reg.size() == 1) begin
      chk("t4_reg", 32'(lg_reg[0]), 2);
      chk("t4_off", 32'(lg_off[0]), 0);
      chk("t4_last", 32'(lg_last[0]), 1);
    end
    chk("t4_first_lat", 32'(first_lat), SKIP ? 1 : 6);
    chk("t4_rel_lat", 32'(rel_lat), SKIP ? 2 : 9);

    // flush during the 2nd of 4 micro-ops, then restart
    clear_meas();
    do_start(1'b0, 3'd1, 8'b1100_1100, 16'h4000);
    run(1);
    flush = 1;
    run(1);
    flush = 0;
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_valid", 32'(uop_valid), 0);
    chk("t5_accepted", 32'(lg_reg.size()), 1);
    chk("t5_no_pulse", 32'(rel_cnt), 0);
    clear_meas();
    do_start(1'b1, 3'd6, 8'b0001_0010, 16'h5000);
    run(14);
    chk("t5_count", 32'(lg_reg.size()), 2);
    if (lg_reg.size() == 2) begin
      chk("t5_reg0", 32'(lg_reg[0]), 4); chk("t5_off0", 32'(lg_off[0]), 0);
      chk("t5_reg1", 32'(lg_reg[1]), 1); chk("t5_off1", 32'(lg_off[1]), 1);
    end
    chk("t5_rel_cnt", 32'(rel_cnt), 1);

    // async reset mid-sequence
    clear_meas();
    do_start(1'b1, 3'd4, 8'hFF, 16'h7777);
    run(2);
    #2 rst_n = 0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(uop_valid), 0);
    chk("t6_release", 32'(freeze_release), 0);
    chk("t6_reg", 32'(uop_reg), 0);
    chk("t6_pc", 32'(uop_pc), 0);
    @(posedge clk); #1;
    rst_n = 1;
    run(12);
    chk("t6_rel_cnt", 32'(rel_cnt), 0);
    chk("t6_busy_after", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle sequencer for load-multiple (LM, opcode 6) and store-multiple (SM, opcode 7) instructions. It sits between decode and the register-read stage. It accepts one LM/SM instruction and freezes fetch/decode while it expands the 8-bit register mask into single-register micro-ops. Each micro-op carries the register index and an address offset, and micro-ops are handed to register-read over a valid/ready handshake.

## Interface
Parameters:
- `MASK_W`, default 8: register-mask width; register index width is `$clog2(MASK_W)`.
- `PC_W`, default 16: program-counter width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: valid LM/SM present at decode; sampled only in IDLE.
- `is_store`, in, 1: 1 = SM, 0 = LM; captured with `start`.
- `base_reg`, in, 3: base-address register (RA); captured with `start`.
- `mask`, in, 8: register mask (imm9[7:0]); captured with `start`.
- `pc_in`, in, 16: instruction PC; captured with `start`.
- `flush`, in, 1: squash in-flight instruction (branch mispredict).
- `uop_ready`, in, 1: register-read accepts the micro-op (its enable).
- `busy`, out, 1: freeze to fetch/decode; high in every non-IDLE state.
- `uop_valid`, out, 1: micro-op present.
- `uop_opcode`, out, 4: 6 or 7.
- `uop_base`, out, 3: base register.
- `uop_reg`, out, 3: register loaded (LM) or stored (SM).
- `uop_offset`, out, 3: word offset added to the base; the first issued micro-op has offset 0.
- `uop_pc`, out, 16: captured PC.
- `uop_last`, out, 1: qualifies the final micro-op.
- `freeze_release`, out, 1: one-cycle pulse when the instruction completes.

## Operation
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - `busy`=0 and `uop_valid`=0.
  - On `start`, capture all inputs into `rem_mask`. Clear the offset counter.
  - If `mask`≠0, go to ISSUE; otherwise go to RELEASE.
- ISSUE:
  - `uop_reg` is the highest set bit of `rem_mask`, so registers are issued in order R7 first down to R0.
  - `uop_valid`=1.
  - `uop_last`=1 when `rem_mask` has exactly one set bit.
  - On `uop_valid && uop_ready`:
    - clear that bit in `rem_mask`;
    - increment the offset counter (3-bit, cannot wrap because there are at most 8 micro-ops);
    - if `uop_last`, go to RELEASE.
  - While `uop_ready`=0, every `uop_*` output holds stable.
- RELEASE: assert `freeze_release` for one cycle, then return to IDLE.
- `flush`, synchronous, any state:
  - on the next edge go to IDLE with `uop_valid`=0;
  - no `freeze_release` pulse is generated;
  - `flush` has priority over `start` and over acceptance in the same cycle.
- The block does not reorder. An LM whose base register is in its own mask is architecturally undefined; it is issued unchanged.
- `start` while `busy`=1 is ignored. Decode is frozen, so this is a protocol error.

## Timing
- Reset values of all outputs are 0, and the state is IDLE. Reset asserted mid-sequence aborts immediately, with no pulse.
- `start` at edge N: the first micro-op is valid after edge N, in cycle N+1.
- With `uop_ready` held high and `LMSM_SKIP_ZERO_EN` defined:
  - k set bits give k consecutive micro-op cycles;
  - `freeze_release` is in cycle N+k+1;
  - `busy` is high in cycles N+1 through N+k+1.
- Empty mask: `freeze_release` in cycle N+1, with no micro-ops.
- Each cycle with `uop_ready`=0 adds one cycle of latency.

## Configuration
- `LMSM_SKIP_ZERO_EN` defined: a priority encoder skips zero mask bits, giving one micro-op per cycle and no bubbles.
- Not defined: the block scans one bit position per cycle from 7 down to 0.
  - Zero bits produce a bubble cycle: `uop_valid`=0, and the offset is not incremented.
  - Completion comes a fixed 8 scan cycles after start; `freeze_release` is in cycle N+9.
  - `uop_last` marks the micro-op for the lowest set bit.

## Structure
- Package `lmsm_pkg`:
  - `OP_LM`=4'd6 and `OP_SM`=4'd7;
  - a state enum `lmsm_state_t` (IDLE, ISSUE, RELEASE);
  - the mask width constant.
- Sub-module `prio_enc8`: combinational highest-set-bit encoder with a `one_hot_left` flag. It is instantiated only when `LMSM_SKIP_ZERO_EN` is defined.

## Test plan
- LM, mask 8'b1010_0001, base R2, ready always high:
  - micro-ops (reg,offset) = (7,0), (5,1), (0,2), with `uop_last` on the third;
  - `freeze_release` in cycle N+4.
- SM, mask 8'hFF, `uop_ready` low for 3 cycles on the 2nd micro-op:
  - outputs stay stable during the stall;
  - 8 micro-ops, offsets 0–7, `uop_opcode`=7;
  - pulse after the last.
- Mask 8'h00: no `uop_valid`; `freeze_release` in cycle N+1; `busy` is high for one cycle.
- `flush` asserted during the 2nd of 4 micro-ops: IDLE next cycle, no pulse. A new `start` the following cycle issues correctly from offset 0.
- `rst_n` pulsed low mid-sequence, asynchronously between edges: all outputs 0 immediately, state IDLE.
- Without `LMSM_SKIP_ZERO_EN`, mask 8'b0000_0100: 5 bubble cycles, then micro-op (2,0) with `uop_last`; `freeze_release` in cycle N+9.
